// File: rtl/berlekamp_massey_solver.sv
// Serial inversionless Berlekamp-Massey solver over GF(2^8).
// Two shared Mastrovito multipliers walk the locator one coefficient per cycle.

module finite_field_multiplier_mastravito (
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  input  logic [56:0] reduction_matrix_i,
  output logic [7:0]  p_o
);
  logic [14:0] prod;
  logic        unused_matrix_msb;

  // Row j (bits 8j+7:8j) holds x^(8+j) mod p(x); bit 56 is reserved.
  assign unused_matrix_msb = reduction_matrix_i[56];

  always_comb begin
    prod = '0;
    for (int j = 0; j < 8; j++) begin
      if (b_i[j]) prod = prod ^ ({7'b0, a_i} << j);
    end
    p_o = prod[7:0];
    for (int j = 0; j < 7; j++) begin
      if (prod[8+j]) p_o = p_o ^ reduction_matrix_i[8*j +: 8];
    end
  end
endmodule

module berlekamp_massey_solver #(
  parameter int MAX_ERRORS = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  input  logic [8*2*MAX_ERRORS-1:0]     syndromes_flat_i,
  input  logic [7*8:0]                  reduction_matrix_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [8*(MAX_ERRORS+1)-1:0]   locator_flat_o,
  output logic [$clog2(2*MAX_ERRORS):0] locator_degree_o,
  output logic                          uncorrectable_o
);
  localparam int T  = MAX_ERRORS;
  localparam int NS = 2 * T;
  localparam int RW = $clog2(NS);
  localparam int LW = RW + 1;
  localparam int IW = $clog2(T + 1);

  typedef enum logic [1:0] {S_IDLE, S_DISC, S_UPDATE, S_FINISH} state_t;

  state_t             state_q, state_d;
  logic [NS-1:0][7:0] syn_q, syn_d;
  logic [T:0][7:0]    lam_q, lam_d, b_q, b_d, loc_q, loc_d;
  logic [LW-1:0]      l_q, l_d, deg_q, deg_d;
  logic [7:0]         gamma_q, gamma_d, delta_q, delta_d;
  logic [RW-1:0]      r_q, r_d;
  logic [IW-1:0]      i_q, i_d;
  logic               upd_q, upd_d, done_q, done_d, unc_q, unc_d;

  logic [RW-1:0] s_idx;
  logic          s_ok;
  logic [7:0]    lam_i, b_prev, m0_a, m0_b, m0_p, m1_p, delta_acc;

  // Multiplier 0 forms the discrepancy term in DISC and gamma*Lambda_i in UPDATE.
  always_comb begin
    s_idx  = r_q - RW'(i_q);
    s_ok   = (r_q >= RW'(i_q));
    lam_i  = lam_q[i_q];
    b_prev = (i_q == '0) ? 8'h00 : b_q[i_q - IW'(1)];
    if (state_q == S_UPDATE) begin
      m0_a = gamma_q;
      m0_b = lam_i;
    end else begin
      m0_a = lam_i;
      m0_b = s_ok ? syn_q[s_idx] : 8'h00;
    end
  end

  assign delta_acc = delta_q ^ m0_p;

  finite_field_multiplier_mastravito u_mul0 (
    .a_i                (m0_a),
    .b_i                (m0_b),
    .reduction_matrix_i (reduction_matrix_i),
    .p_o                (m0_p)
  );

  finite_field_multiplier_mastravito u_mul1 (
    .a_i                (delta_q),
    .b_i                (b_prev),
    .reduction_matrix_i (reduction_matrix_i),
    .p_o                (m1_p)
  );

  always_comb begin
    state_d = state_q;
    syn_d   = syn_q;
    lam_d   = lam_q;
    b_d     = b_q;
    loc_d   = loc_q;
    l_d     = l_q;
    deg_d   = deg_q;
    gamma_d = gamma_q;
    delta_d = delta_q;
    r_d     = r_q;
    i_d     = i_q;
    upd_d   = upd_q;
    done_d  = done_q;
    unc_d   = unc_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          syn_d    = syndromes_flat_i;
          lam_d    = '0;
          lam_d[0] = 8'h01;
          b_d      = '0;
          b_d[0]   = 8'h01;
          l_d      = '0;
          gamma_d  = 8'h01;
          delta_d  = 8'h00;
          r_d      = '0;
          i_d      = '0;
          upd_d    = 1'b0;
          done_d   = 1'b0;
          unc_d    = 1'b0;
          state_d  = S_DISC;
        end
      end
      S_DISC: begin
        delta_d = delta_acc;
        if (i_q == IW'(T)) begin
          upd_d   = (delta_acc != 8'h00) && ({l_q, 1'b0} <= {2'b00, r_q});
          state_d = S_UPDATE;
        end else begin
          i_d = i_q + IW'(1);
        end
      end
      S_UPDATE: begin
        // Descending i keeps Lambda_i and B_(i-1) at their old values here.
        lam_d[i_q] = m0_p ^ m1_p;
        b_d[i_q]   = upd_q ? lam_i : b_prev;
        if (i_q == '0) begin
          if (upd_q) begin
            l_d     = LW'(r_q) + LW'(1) - l_q;
            gamma_d = delta_q;
          end
          delta_d = 8'h00;
          if (r_q == RW'(NS - 1)) begin
            state_d = S_FINISH;
          end else begin
            r_d     = r_q + RW'(1);
            state_d = S_DISC;
          end
        end else begin
          i_d = i_q - IW'(1);
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        unc_d   = (l_q > LW'(T));
        loc_d   = lam_q;
        deg_d   = l_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      syn_q   <= '0;
      lam_q   <= '0;
      b_q     <= '0;
      loc_q   <= '0;
      l_q     <= '0;
      deg_q   <= '0;
      gamma_q <= '0;
      delta_q <= '0;
      r_q     <= '0;
      i_q     <= '0;
      upd_q   <= 1'b0;
      done_q  <= 1'b0;
      unc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      syn_q   <= syn_d;
      lam_q   <= lam_d;
      b_q     <= b_d;
      loc_q   <= loc_d;
      l_q     <= l_d;
      deg_q   <= deg_d;
      gamma_q <= gamma_d;
      delta_q <= delta_d;
      r_q     <= r_d;
      i_q     <= i_d;
      upd_q   <= upd_d;
      done_q  <= done_d;
      unc_q   <= unc_d;
    end
  end

  assign busy_o           = (state_q != S_IDLE);
  assign done_o           = done_q;
  assign locator_flat_o   = loc_q;
  assign locator_degree_o = deg_q;
  assign uncorrectable_o  = unc_q;
endmodule

// File: tb/tb_berlekamp_massey_solver.sv
// Directed bench for berlekamp_massey_solver: a t=16 and a t=2 instance
// sharing one clock and reset, hand-computed GF(2^8)/0x11D expectations.
module tb_berlekamp_massey_solver;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         start16, start2;
  logic [255:0] syn16;
  logic [31:0]  syn2;
  logic [56:0]  red;
  logic         busy16, done16, unc16, busy2, done2, unc2;
  logic [135:0] loc16;
  logic [23:0]  loc2;
  logic [5:0]   deg16;
  logic [2:0]   deg2;

  int checks = 0;
  int errors = 0;
  int lat;
  logic [7:0] l0;

  localparam logic [255:0] ONES = {32{8'h01}};

  typedef struct {
    logic [31:0] syn;
    logic [23:0] lam;
    logic [2:0]  deg;
    logic        unc;
  } vec_t;
  vec_t vecs [6];

  always #5 clk = ~clk;

  berlekamp_massey_solver #(.MAX_ERRORS(16)) dut16 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start16), .syndromes_flat_i(syn16),
    .reduction_matrix_i(red), .busy_o(busy16), .done_o(done16),
    .locator_flat_o(loc16), .locator_degree_o(deg16), .uncorrectable_o(unc16)
  );

  berlekamp_massey_solver #(.MAX_ERRORS(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start2), .syndromes_flat_i(syn2),
    .reduction_matrix_i(red), .busy_o(busy2), .done_o(done2),
    .locator_flat_o(loc2), .locator_degree_o(deg2), .uncorrectable_o(unc2)
  );

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    end
    return p;
  endfunction

  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_done(input bit big, inout int n);
    while (((big ? done16 : done2) !== 1'b1) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic run(input bit big, input logic [255:0] syn, output int n);
    @(negedge clk);
    if (big) begin
      syn16   = syn;
      start16 = 1'b1;
    end else begin
      syn2   = syn[31:0];
      start2 = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    start16 = 1'b0;
    start2  = 1'b0;
    n = 0;
    wait_done(big, n);
  endtask

  initial begin
    rst_n   = 1'b0;
    start16 = 1'b0;
    start2  = 1'b0;
    syn16   = '0;
    syn2    = '0;
    red     = {1'b0, 8'h13, 8'h87, 8'hCD, 8'hE8, 8'h74, 8'h3A, 8'h1D};

    // {S3,S2,S1,S0} -> {L2,L1,L0}, degree, uncorrectable
    vecs[0] = '{32'h00000000, 24'h000001, 3'd0, 1'b0};
    vecs[1] = '{32'h01010101, 24'h000101, 3'd1, 1'b0};
    vecs[2] = '{32'h09050300, 24'h0A0F05, 3'd2, 1'b0};
    vecs[3] = '{32'h01000000, 24'h000001, 3'd4, 1'b1};
    vecs[4] = '{32'h02020202, 24'h000808, 3'd1, 1'b0};
    vecs[5] = '{32'h80808080, 24'h007575, 3'd1, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_flags16", 136'({busy16, done16, unc16, deg16}), 136'd0);
    chk("reset_loc16", loc16, 136'd0);
    chk("reset_all2", 136'({busy2, done2, unc2, deg2, loc2}), 136'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run(1'b1, '0, lat);
    chk("zero16_lat", 136'(lat), 136'd1089);
    chk("zero16_loc", loc16, 136'h01);
    chk("zero16_deg_unc_busy", 136'({deg16, unc16, busy16}), 136'd0);

    run(1'b1, ONES, lat);
    chk("ones16_lat", 136'(lat), 136'd1089);
    chk("ones16_loc", loc16, 136'h0101);
    chk("ones16_deg_unc", 136'({deg16, unc16}), 136'({6'd1, 1'b0}));

    // asynchronous reset in the middle of the first DISC pass
    @(negedge clk);
    syn16   = '0;
    start16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start16 = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk("pre_reset_busy", 136'(busy16), 136'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_flags", 136'({busy16, done16, unc16, deg16}), 136'd0);
    chk("async_reset_loc", loc16, 136'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(1'b1, ONES, lat);
    chk("post_reset_lat", 136'(lat), 136'd1089);
    chk("post_reset_loc", loc16, 136'h0101);
    chk("post_reset_deg", 136'(deg16), 136'd1);

    for (int k = 0; k < 6; k++) begin
      run(1'b0, {224'h0, vecs[k].syn}, lat);
      chk($sformatf("v%0d_lat", k), 136'(lat), 136'd25);
      chk($sformatf("v%0d_loc", k), 136'(loc2), 136'(vecs[k].lam));
      chk($sformatf("v%0d_deg", k), 136'(deg2), 136'(vecs[k].deg));
      chk($sformatf("v%0d_unc", k), 136'(unc2), 136'(vecs[k].unc));
    end

    // start with other syndromes at cycle 10 of a busy solve must be ignored
    @(negedge clk);
    syn2   = vecs[2].syn;
    start2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start2 = 1'b0;
    lat = 0;
    repeat (9) begin
      @(posedge clk);
      #1;
      lat++;
    end
    @(negedge clk);
    syn2   = vecs[5].syn;
    start2 = 1'b1;
    @(posedge clk);
    #1;
    lat++;
    @(negedge clk);
    start2 = 1'b0;
    wait_done(1'b0, lat);
    chk("ignored_start_lat", 136'(lat), 136'd25);
    chk("ignored_start_loc", 136'(loc2), 136'(vecs[2].lam));
    chk("ignored_start_deg", 136'(deg2), 136'd2);
    l0 = loc2[7:0];
    chk("two_err_roots", 136'(loc2), 136'({gf_mul(l0, 8'h02), gf_mul(l0, 8'h03), l0}));

    // start held high across the return to IDLE
    @(negedge clk);
    syn16   = '0;
    start16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    syn16 = ONES;
    lat = 0;
    wait_done(1'b1, lat);
    chk("b2b_first_lat", 136'(lat), 136'd1089);
    chk("b2b_first_loc", loc16, 136'h01);
    @(posedge clk);
    #1;
    chk("b2b_done_pulse", 136'({done16, busy16}), 136'(2'b01));
    @(negedge clk);
    start16 = 1'b0;
    lat = 1;
    wait_done(1'b1, lat);
    chk("b2b_period", 136'(lat), 136'd1090);
    chk("b2b_second_loc", loc16, 136'h0101);
    chk("b2b_second_deg", 136'(deg16), 136'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/berlekamp_massey_solver.md
# berlekamp_massey_solver

Iterative, inversionless Berlekamp-Massey stage that consumes the 2·MAX_ERRORS syndromes from the serial syndrome calculator and produces the error-locator polynomial Λ(x) for the downstream Chien search. Arithmetic is over GF(2^8), with the same runtime-programmable `reduction_matrix` the rest of the decoder uses. The block uses two shared combinational `finite_field_multiplier_mastravito` instances and walks polynomial coefficients serially. This trades latency for area.

## Interface
- `MAX_ERRORS`, 16, t; correctable symbol errors. 2t syndromes in; t+1 locator coefficients out.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-low reset. Asserts immediately and releases synchronously to `clk`.
- `start` in 1: sampled in IDLE only. Normally driven by the syndrome calculator's `done`.
- `syndromes_flat` in 8·2t: S_j at bits [8j+7:8j], j=0..2t-1. Snapshotted into an internal register on the accepted `start`.
- `reduction_matrix` in 57 ([7*8:0]): GF reduction matrix, passed unchanged to both multipliers. Must be stable while `busy`.
- `busy` out 1: high from the cycle after `start` is accepted until `done` rises.
- `done` out 1: level signal. Stays high until the next accepted `start` or reset.
- `locator_flat` out 8·(t+1): Λ_i at bits [8i+7:8i]. Valid while `done`.
- `locator_degree` out $clog2(2t)+1: final L.
- `uncorrectable` out 1: high with `done` when L > t.

## Operation
- States: IDLE → DISC → UPDATE → (DISC | FINISH) → IDLE.
- Iteration counter r runs 0..2t-1. Coefficient counter i runs 0..t.
- IDLE, `start`=1:
  - Snapshot syndromes.
  - Set Λ=1, B=1, L=0, γ=1, r=0, δ=0.
  - Clear `done`. Go to DISC with i=0.
- DISC, t+1 cycles, i ascending:
  - δ ^= Λ_i · S_{r-i}. The term is 0 when r-i < 0.
  - On the last cycle, latch the branch flag: upd = (δ≠0) && (2L ≤ r).
  - Go to UPDATE with i=t.
- UPDATE, t+1 cycles, i descending t..0, in place:
  - Λ_i ← γ·Λ_i ^ δ·B_{i-1}, where B_{-1}=0.
  - B_i ← upd ? Λ_i(old) : B_{i-1}.
  - Descending order guarantees B_{i-1} and Λ_i are still the old values when read.
  - On the i=0 cycle:
    - If upd: L ← r+1-L and γ ← δ.
    - Clear δ.
    - If r=2t-1 go to FINISH; else r ← r+1 and go to DISC with i=0.
- FINISH, 1 cycle: assert `done`, drive `uncorrectable` = (L > t), go to IDLE.
- Coefficients above index t are dropped. Truncation is only possible when L > t, and that case is flagged by `uncorrectable`.
- Λ is not normalised (Λ_0 = product of the γ values, always nonzero). Roots are unaffected.
- All additions are XOR. There are no carries and no width growth. L ≤ 2t fits in `locator_degree`.

## Timing
- Reset values:
  - `busy`=0, `done`=0, `uncorrectable`=0.
  - `locator_flat`=0, `locator_degree`=0.
  - State IDLE, all counters 0.
- Latency: `start` sampled at edge N → `done` high after edge N + 4t(t+1) + 1.
  - t=16: 1089 cycles.
  - t=2: 25 cycles.
- `busy` and `done` are never high together. `busy` falls on the same edge `done` rises.
- `start` while `busy` is ignored, and the snapshot is not disturbed.
- `start` in IDLE while `done`=1 restarts the block. `done` drops on the next edge.
- `start` held high continuously: a new solve begins on each return to IDLE (one idle cycle between solves).
- Reset mid-operation returns all outputs and state to their reset values immediately. The partial result is discarded.
- Outputs change only in UPDATE/FINISH. `locator_flat` is stable whenever `done`=1.

## Test plan
- Reset: assert `rst`=0 mid-DISC → `busy`=0, `done`=0, `locator_flat`=0 asynchronously. After release, a new `start` completes normally.
- All-zero syndromes, t=16 → `done` exactly 1089 cycles after `start`, Λ_0=0x01, Λ_1..Λ_16=0, `locator_degree`=0, `uncorrectable`=0.
- All syndromes = 0x01 (single error of value 1 at position 0), t=16 → Λ_0=0x01, Λ_1=0x01, Λ_2..Λ_16=0, `locator_degree`=1, `uncorrectable`=0.
- Check the two-error case, using the standard 0x11D reduction matrix and t=2:
  - Stimulus: syndromes from errors 0x01 at positions 0 and 1.
  - Required: `locator_degree`=2 and Λ has roots exactly at α^0 and α^-1.
  - Compare against the software reference after scaling by Λ_0⁻¹.
- `start` pulsed at cycle 10 of a solve with different syndromes → ignored. Original result and latency are unchanged.
- Back-to-back solves with `start` tied high → `done` pulses high for one cycle every 1090 cycles. Results match each snapshot.
